// File: rtl/psum_drain_ctrl_if.sv
// rtl/psum_drain_ctrl_if.sv - GLB read port and output stream bundle for psum_drain_ctrl
//
// master (controller side):
//   r_req_psum  out  GLB read request
//   r_addr_psum out  GLB read address
//   r_data_psum in   GLB read data, valid one cycle after r_req_psum
//   out_data    out  stream data
//   out_valid   out  stream valid
//   out_last    out  last word of a row
//   out_ready   in   stream ready
// slave: the same signals seen from the GLB / output DMA side.
interface psum_drain_ctrl_if #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10
);
    logic                     r_req_psum;
    logic [ADDR_BITWIDTH-1:0] r_addr_psum;
    logic [DATA_BITWIDTH-1:0] r_data_psum;
    logic [DATA_BITWIDTH-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        output r_req_psum, r_addr_psum, out_data, out_valid, out_last,
        input  r_data_psum, out_ready
    );

    modport slave (
        input  r_req_psum, r_addr_psum, out_data, out_valid, out_last,
        output r_data_psum, out_ready
    );
endinterface

// File: rtl/psum_drain_ctrl.sv
// rtl/psum_drain_ctrl.sv - reads one psum row from the GLB and streams it out through a credit FIFO
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-low reset
//   drain_start in   one-cycle pulse: drain the current row (ignored while busy)
//   bus         master modport of psum_drain_ctrl_if (GLB read port + output stream)
//   busy        out  high from accepted drain_start until row_done
//   row_done    out  one-cycle pulse, row fully delivered
//   tile_done   out  one-cycle pulse with row_done of the last row
//   row_idx     out  row currently / next drained
module psum_drain_ctrl #(
    parameter int DATA_BITWIDTH  = 16,
    parameter int ADDR_BITWIDTH  = 10,
    parameter int X_dim          = 8,
    parameter int PSUM_LOAD_ADDR = 0,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     drain_start,
    psum_drain_ctrl_if.master        bus,
    output logic                     busy,
    output logic                     row_done,
    output logic                     tile_done,
    output logic [$clog2(X_dim)-1:0] row_idx
);
    localparam int IDX_W = $clog2(X_dim);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(X_dim - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] row_q, row_d;

    // FIFO entry = {last tag, data}
    logic [DATA_BITWIDTH:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   inflight_q, inflight_last_q;

    logic issue, push, pop, fifo_empty;

    assign fifo_empty = (count_q == '0);
    // The in-flight read already owns a FIFO slot, so it is counted as a credit.
    assign issue = (state_q == S_READ) &&
                   ((count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
    // GLB data arrives exactly one cycle after the request, so capture is just the in-flight flag.
    assign push = inflight_q;
    assign pop  = !fifo_empty && bus.out_ready;

    assign bus.r_req_psum  = issue;
    assign bus.r_addr_psum = issue ? (ADDR_BITWIDTH'(PSUM_LOAD_ADDR)
                                      + ADDR_BITWIDTH'(row_q) * ADDR_BITWIDTH'(X_dim)
                                      + ADDR_BITWIDTH'(col_q)) : '0;

    // Head entry is gated so the stream reads all-zero while empty.
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? '0 : fifo_q[rd_ptr_q][DATA_BITWIDTH-1:0];
    assign bus.out_last  = !fifo_empty && fifo_q[rd_ptr_q][DATA_BITWIDTH];

    assign busy    = (state_q != S_IDLE);
    assign row_idx = row_q;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        row_done  = 1'b0;
        tile_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (drain_start) begin
                    state_d = S_READ;
                    col_d   = '0;
                end
            end
            S_READ: begin
                if (issue) begin
                    if (col_q == LAST_IDX) begin
                        col_d   = '0;
                        state_d = S_FLUSH;
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (fifo_empty && !inflight_q) state_d = S_DONE;
            end
            S_DONE: begin
                row_done = 1'b1;
                if (row_q == LAST_IDX) begin
                    tile_done = 1'b1;
                    row_d     = '0;
                end else begin
                    row_d = row_q + IDX_W'(1);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            col_q           <= '0;
            row_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            col_q           <= col_d;
            row_q           <= row_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (col_q == LAST_IDX);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {inflight_last_q, bus.r_data_psum};
    end
endmodule

// File: tb/tb_psum_drain_ctrl.sv
// tb/tb_psum_drain_ctrl.sv - self-checking bench for psum_drain_ctrl
module tb_psum_drain_ctrl;
    localparam int DW = 16;
    localparam int AW = 10;
    localparam int XD = 8;
    localparam int DEPTH = 4;
    localparam int BASE0 = 0;
    localparam int BASE1 = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          ds [2];
    logic          rdy [2];
    logic [DW-1:0] rdata [2];
    logic          req [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] data [2];
    logic          valid [2];
    logic          last [2];
    logic          busy [2];
    logic          rdone [2];
    logic          tdone [2];
    logic [2:0]    ridx [2];

    psum_drain_ctrl_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) bus0 ();
    psum_drain_ctrl_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) bus1 ();

    psum_drain_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD),
                      .PSUM_LOAD_ADDR(BASE0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .reset(resetn), .drain_start(ds[0]), .bus(bus0),
        .busy(busy[0]), .row_done(rdone[0]), .tile_done(tdone[0]), .row_idx(ridx[0]));

    psum_drain_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .X_dim(XD),
                      .PSUM_LOAD_ADDR(BASE1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .reset(resetn), .drain_start(ds[1]), .bus(bus1),
        .busy(busy[1]), .row_done(rdone[1]), .tile_done(tdone[1]), .row_idx(ridx[1]));

    assign bus0.r_data_psum = rdata[0];
    assign bus0.out_ready   = rdy[0];
    assign bus1.r_data_psum = rdata[1];
    assign bus1.out_ready   = rdy[1];
    assign req[0]   = bus0.r_req_psum;
    assign addr[0]  = bus0.r_addr_psum;
    assign data[0]  = bus0.out_data;
    assign valid[0] = bus0.out_valid;
    assign last[0]  = bus0.out_last;
    assign req[1]   = bus1.r_req_psum;
    assign addr[1]  = bus1.r_addr_psum;
    assign data[1]  = bus1.out_data;
    assign valid[1] = bus1.out_valid;
    assign last[1]  = bus1.out_last;

    // GLB model: word at address a holds a+100; garbage when not requested.
    always @(posedge clk) begin
        rdata[0] <= req[0] ? DW'(addr[0]) + DW'(100) : DW'($urandom);
        rdata[1] <= req[1] ? DW'(addr[1]) + DW'(100) : DW'($urandom);
    end

    int asserts = 0;
    int fails = 0;
    int sel = 0;
    int model_row = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int addr_q[$];
    int reqc_q[$];
    int word_q[$];
    bit last_q[$];
    int rd_q[$];
    int td_q[$];
    int issued = 0;
    int popped = 0;
    int max_out = 0;
    int first_valid = -1;

    always @(negedge clk) begin
        if (req[sel] === 1'b1) begin
            addr_q.push_back(int'(addr[sel]));
            reqc_q.push_back(cyc);
            issued++;
        end
        if (issued - popped > max_out) max_out = issued - popped;
        if (valid[sel] === 1'b1 && first_valid < 0) first_valid = cyc;
        if (valid[sel] === 1'b1 && rdy[sel] === 1'b1) begin
            word_q.push_back(int'(data[sel]));
            last_q.push_back(last[sel]);
            popped++;
        end
        if (rdone[sel] === 1'b1) rd_q.push_back(cyc);
        if (tdone[sel] === 1'b1) td_q.push_back(cyc);
    end

    function automatic int exp_addr(input int base, input int j);
        return (base + j) % 1024;
    endfunction

    task automatic clear_mon();
        addr_q.delete(); reqc_q.delete(); word_q.delete(); last_q.delete();
        rd_q.delete(); td_q.delete();
        issued = 0; popped = 0; max_out = 0; first_valid = -1;
    endtask

    task automatic start_row(output int c0);
        ds[sel] = 1'b1;
        @(posedge clk); #1;
        ds[sel] = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_rows(input int n, input int bound);
        int k = 0;
        while (rd_q.size() < n && k < bound) begin
            @(posedge clk); #1;
            k++;
        end
        asserts++;
        if (rd_q.size() < n) begin
            fails++;
            $display("FAIL wait_rows: row_done count %0d, required %0d", rd_q.size(), n);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        model_row = 0;
    endtask

    // Compare the collected stream against row(s) starting at flat word index j0.
    task automatic check_words(input string name, input int base, input int j0, input int n);
        int bad = 0;
        asserts++;
        if (word_q.size() != n) begin
            fails++;
            $display("FAIL %s word count: got %0d, required %0d", name, word_q.size(), n);
        end
        for (int k = 0; k < n && k < word_q.size(); k++) begin
            if (word_q[k] != exp_addr(base, j0 + k) + 100 || last_q[k] != ((k % XD) == XD - 1)) begin
                if (bad == 0)
                    $display("FAIL %s word %0d: got %0d last %0d, required %0d last %0d", name, k,
                             word_q[k], last_q[k], exp_addr(base, j0 + k) + 100, (k % XD) == XD - 1);
                bad++;
            end
        end
        asserts++;
        if (bad != 0) fails++;
    endtask

    task automatic check_addrs(input string name, input int base, input int j0, input int n);
        int bad = 0;
        asserts++;
        if (addr_q.size() != n) begin
            fails++;
            $display("FAIL %s read count: got %0d, required %0d", name, addr_q.size(), n);
        end
        for (int k = 0; k < n && k < addr_q.size(); k++) begin
            if (addr_q[k] != exp_addr(base, j0 + k)) begin
                if (bad == 0)
                    $display("FAIL %s addr %0d: got %0d, required %0d", name, k, addr_q[k], exp_addr(base, j0 + k));
                bad++;
            end
        end
        asserts++;
        if (bad != 0) fails++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin ds[i] = 1'b0; rdy[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            asserts++; if (req[i] !== 1'b0)   begin fails++; $display("FAIL reset r_req[%0d]: got %b, required 0", i, req[i]); end
            asserts++; if (addr[i] !== '0)    begin fails++; $display("FAIL reset r_addr[%0d]: got %0d, required 0", i, addr[i]); end
            asserts++; if (valid[i] !== 1'b0) begin fails++; $display("FAIL reset out_valid[%0d]: got %b, required 0", i, valid[i]); end
            asserts++; if (data[i] !== '0)    begin fails++; $display("FAIL reset out_data[%0d]: got %0d, required 0", i, data[i]); end
            asserts++; if (last[i] !== 1'b0)  begin fails++; $display("FAIL reset out_last[%0d]: got %b, required 0", i, last[i]); end
            asserts++; if (busy[i] !== 1'b0)  begin fails++; $display("FAIL reset busy[%0d]: got %b, required 0", i, busy[i]); end
            asserts++; if (rdone[i] !== 1'b0) begin fails++; $display("FAIL reset row_done[%0d]: got %b, required 0", i, rdone[i]); end
            asserts++; if (tdone[i] !== 1'b0) begin fails++; $display("FAIL reset tile_done[%0d]: got %b, required 0", i, tdone[i]); end
            asserts++; if (ridx[i] !== 3'd0)  begin fails++; $display("FAIL reset row_idx[%0d]: got %0d, required 0", i, ridx[i]); end
        end
        resetn = 1'b1;
        model_row = 0;
    endtask

    task automatic test_basic_row();
        int c0;
        int bad = 0;
        sel = 0;
        rdy[0] = 1'b1;
        clear_mon();
        start_row(c0);
        wait_rows(1, 50);
        check_addrs("basic", BASE0, model_row * XD, XD);
        for (int k = 0; k < reqc_q.size(); k++) if (reqc_q[k] != c0 + k) bad++;
        asserts++;
        if (bad != 0) begin fails++; $display("FAIL basic read timing: %0d reads off their cycle, required 0", bad); end
        check_words("basic", BASE0, model_row * XD, XD);
        asserts++;
        if (first_valid != c0 + 2) begin fails++; $display("FAIL basic first valid: got cycle +%0d, required +2", first_valid - c0); end
        asserts++;
        if (rd_q.size() < 1 || rd_q[0] != c0 + XD + 3) begin
            fails++; $display("FAIL basic row_done latency: got +%0d, required +%0d", rd_q.size() ? rd_q[0] - c0 : -1, XD + 3);
        end
        asserts++;
        if (td_q.size() != 0) begin fails++; $display("FAIL basic tile_done: got %0d pulses, required 0", td_q.size()); end
        model_row = (model_row + 1) % XD;
        asserts++;
        if (ridx[0] !== 3'(model_row)) begin fails++; $display("FAIL basic row_idx: got %0d, required %0d", ridx[0], model_row); end
    endtask

    task automatic test_back_pressure();
        int c0;
        int unstable = 0;
        int head = exp_addr(BASE0, model_row * XD) + 100;
        sel = 0;
        rdy[0] = 1'b0;
        clear_mon();
        start_row(c0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i >= 2 && (valid[0] !== 1'b1 || int'(data[0]) != head)) unstable++;
        end
        asserts++;
        if (issued != DEPTH) begin fails++; $display("FAIL backpressure reads: got %0d, required %0d", issued, DEPTH); end
        asserts++;
        if (req[0] !== 1'b0) begin fails++; $display("FAIL backpressure r_req: got %b, required 0", req[0]); end
        asserts++;
        if (unstable != 0) begin fails++; $display("FAIL backpressure hold: %0d cycles without data %0d, required 0", unstable, head); end
        @(posedge clk); #1;
        rdy[0] = 1'b1;
        wait_rows(1, 100);
        check_addrs("backpressure", BASE0, model_row * XD, XD);
        check_words("backpressure", BASE0, model_row * XD, XD);
        asserts++;
        if (max_out > DEPTH) begin fails++; $display("FAIL backpressure occupancy: got %0d, required <= %0d", max_out, DEPTH); end
        model_row = (model_row + 1) % XD;
    endtask

    task automatic test_ignored_start();
        int c0;
        sel = 0;
        rdy[0] = 1'b1;
        clear_mon();
        start_row(c0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ds[0] = 1'b1;
        @(posedge clk); #1;
        ds[0] = 1'b0;
        wait_rows(1, 50);
        repeat (15) @(posedge clk);
        #1;
        asserts++;
        if (rd_q.size() != 1) begin fails++; $display("FAIL ignored_start row_done: got %0d, required 1", rd_q.size()); end
        check_addrs("ignored_start", BASE0, model_row * XD, XD);
        check_words("ignored_start", BASE0, model_row * XD, XD);
        model_row = (model_row + 1) % XD;
    endtask

    task automatic test_full_tile();
        int c0;
        sel = 0;
        rdy[0] = 1'b1;
        apply_reset();
        clear_mon();
        for (int r = 0; r < XD; r++) begin
            start_row(c0);
            wait_rows(r + 1, 50);
        end
        check_addrs("tile", BASE0, 0, XD * XD);
        check_words("tile", BASE0, 0, XD * XD);
        asserts++;
        if (td_q.size() != 1 || rd_q.size() != XD || td_q[0] != rd_q[XD - 1]) begin
            fails++; $display("FAIL tile tile_done: got %0d pulses, required 1 with last row_done", td_q.size());
        end
        asserts++;
        if (ridx[0] !== 3'd0) begin fails++; $display("FAIL tile row_idx wrap: got %0d, required 0", ridx[0]); end
        model_row = 0;
    endtask

    task automatic test_reset_mid_row();
        int c0;
        int k = 0;
        sel = 0;
        rdy[0] = 1'b1;
        clear_mon();
        start_row(c0);
        while (popped < 3 && k < 50) begin @(posedge clk); #1; k++; end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        model_row = 0;
        @(negedge clk);
        asserts++; if (valid[0] !== 1'b0) begin fails++; $display("FAIL midreset out_valid: got %b, required 0", valid[0]); end
        asserts++; if (busy[0] !== 1'b0)  begin fails++; $display("FAIL midreset busy: got %b, required 0", busy[0]); end
        asserts++; if (ridx[0] !== 3'd0)  begin fails++; $display("FAIL midreset row_idx: got %0d, required 0", ridx[0]); end
        @(posedge clk); #1;
        clear_mon();
        start_row(c0);
        wait_rows(1, 50);
        check_addrs("midreset", BASE0, 0, XD);
        check_words("midreset", BASE0, 0, XD);
        model_row = 1;
    endtask

    task automatic test_random_ready();
        int started = 0;
        int k = 0;
        sel = 1;
        rdy[0] = 1'b0;
        apply_reset();
        clear_mon();
        ds[1] = 1'b0;
        while ((started < XD || rd_q.size() < XD) && k < 3000) begin
            rdy[1] = 1'($urandom_range(0, 1));
            if (ds[1]) ds[1] = 1'b0;
            else if (!busy[1] && started < XD) begin ds[1] = 1'b1; started++; end
            @(posedge clk); #1;
            k++;
        end
        ds[1] = 1'b0;
        rdy[1] = 1'b1;
        asserts++;
        if (rd_q.size() != XD) begin fails++; $display("FAIL random row_done: got %0d, required %0d", rd_q.size(), XD); end
        check_addrs("random", BASE1, 0, XD * XD);
        check_words("random", BASE1, 0, XD * XD);
        asserts++;
        if (max_out > DEPTH) begin fails++; $display("FAIL random occupancy: got %0d, required <= %0d", max_out, DEPTH); end
        asserts++;
        if (td_q.size() != 1 || rd_q.size() != XD || td_q[0] != rd_q[XD - 1]) begin
            fails++; $display("FAIL random tile_done: got %0d pulses, required 1 with last row_done", td_q.size());
        end
        asserts++;
        if (ridx[1] !== 3'd0) begin fails++; $display("FAIL random row_idx wrap: got %0d, required 0", ridx[1]); end
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_back_pressure();
        test_ignored_start();
        test_full_tile();
        test_reset_mid_row();
        test_random_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/psum_drain_ctrl.md
Name: psum_drain_ctrl

Overview:
- Hardware reader for one cluster's psum GLB; replaces bench-driven r_req/r_addr sequencing after each compute pass.
- On a drain request it reads the X_dim psums of the current output row from the GLB read port.
- Results leave on a valid/ready stream through a small credit-controlled FIFO, so back-pressure never drops a word.
- One instance per cluster (west_0, west_1, east_0, east_1), placed between the psum GLB and the output DMA.

Parameters:
DATA_BITWIDTH, 16, psum word width
ADDR_BITWIDTH, 10, GLB address width
X_dim, 8, psums per row and rows per tile
PSUM_LOAD_ADDR, 0, GLB base address of the psum tile
FIFO_DEPTH, 4, output buffer entries (power of two, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
drain_start  in  1  one-cycle pulse (driven from compute_done): drain current row
r_req_psum  out  1  GLB read request
r_addr_psum  out  ADDR_BITWIDTH  GLB read address
r_data_psum  in  DATA_BITWIDTH  GLB read data, valid exactly 1 cycle after r_req_psum
out_data  out  DATA_BITWIDTH  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_last  out  1  high with the last word of a row
busy  out  1  high from accepted drain_start until row_done
row_done  out  1  one-cycle pulse, row fully delivered
tile_done  out  1  one-cycle pulse with row_done of row X_dim-1
row_idx  out  clog2(X_dim)  row currently/next drained

Behaviour:
- Reset (reset==0 at a rising edge): FSM=IDLE, FIFO emptied, in-flight flag cleared, row_idx=0, col=0. All outputs 0. Reset mid-drain aborts the drain; nothing already read is delivered.
- FSM states:
  - IDLE: drain_start -> READ, col=0, busy=1.
  - READ: issues reads. After col X_dim-1 is issued -> FLUSH.
  - FLUSH: waits until FIFO empty and no read in flight -> DONE.
  - DONE: one cycle; row_done=1. If row_idx==X_dim-1, also tile_done=1 and row_idx wraps to 0; otherwise row_idx+1. Then -> IDLE.
- Read issue, in READ only: assert r_req_psum when fifo_count + inflight < FIFO_DEPTH.
  - r_addr_psum = PSUM_LOAD_ADDR + row_idx*X_dim + col, computed at full ADDR_BITWIDTH, modulo 2^ADDR_BITWIDTH.
  - col increments on each issued read.
- Capture: the cycle after r_req_psum, r_data_psum is pushed into the FIFO. inflight is 1 bit: set on issue, cleared on capture. Back-to-back issue is allowed because the credit check counts the in-flight read.
- out_last is tagged on push for col X_dim-1 and travels with its word.
- Stream rules:
  - out_valid = FIFO not empty. out_data/out_last come from the FIFO head.
  - A pop happens on out_valid && out_ready.
  - A push and a pop in the same cycle leave the count unchanged.
  - With the FIFO full no further read issues, so no overflow is possible.
  - out_data is stable while out_valid && !out_ready.
- drain_start while busy (READ/FLUSH/DONE) is ignored; no queuing.
- Throughput: with out_ready held 1, one word per cycle. First out_valid appears 2 cycles after drain_start (issue cycle, then capture). The row completes in X_dim+3 cycles from drain_start to row_done.

Test Plan:
- Basic row: GLB[i]=i+100, out_ready=1, drain_start -> addresses 0..7 on consecutive cycles; out_data 100..107; out_last only on 107; row_done 11 cycles after drain_start.
- Back-pressure: out_ready=0 for 20 cycles after drain_start -> exactly 4 reads issued, r_req_psum then low, out_data holds 100. On release, remaining words 104..107 follow in order with no loss or duplicates.
- Full tile: 8 drain_starts, each waiting for row_done -> row r reads addresses 8r..8r+7; tile_done pulses only with row 7; row_idx returns to 0.
- Ignored start: drain_start pulsed again on cycle 3 of a drain -> no extra reads, single row_done.
- Reset mid-row: reset=0 for one cycle after 3 words delivered -> out_valid=0, busy=0, row_idx=0. The next drain_start rereads from address 0.
- Random ready: 50% random out_ready over a full tile, PSUM_LOAD_ADDR=1000 -> address wraps modulo 1024 (1000..1063 mod 1024), all 64 words in order, FIFO count never exceeds 4.
